// File: rtl/match_game_ctrl_if.sv
// Card memory bus between the game sequencer (master) and the 16x5 card RAM (slave).
// The read data is combinational for mem_addr, so it is valid in the same cycle.
interface match_game_ctrl_if;
  logic [3:0] mem_addr;
  logic [4:0] mem_wdata;
  logic       mem_we;
  logic [4:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/match_game_ctrl.sv
// Two-player 4x4 card-matching sequencer: clear, deal, shuffle, flip, show, resolve, score.
// start to first WAIT1 is 77 cycles; while busy is high a flip is dropped, never queued.
module match_game_ctrl #(
  parameter int SHOW_CYCLES = 12_500_000,
  parameter int TIMER_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              flip,
  input  logic [3:0]        sel_pos,
  input  logic [3:0]        rand_val,
  match_game_ctrl_if.master mem,
  output logic [1:0]        game_state,
  output logic [3:0]        p1_score,
  output logic [3:0]        p2_score,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_SHUF_RI,
    S_SHUF_RJ,
    S_SHUF_WI,
    S_SHUF_WJ,
    S_WAIT1,
    S_WAIT2,
    S_SHOW,
    S_RES_A,
    S_RES_B,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_HIDDEN  = 2'b00;
  localparam logic [1:0] ST_FACEUP  = 2'b01;
  localparam logic [1:0] ST_MATCHED = 2'b10;

  state_t             state;
  logic [3:0]         idx;
  logic [3:0]         jdx;
  logic [4:0]         ti;
  logic [4:0]         tj;
  logic [3:0]         first_pos;
  logic [3:0]         second_pos;
  logic [2:0]         first_face;
  logic [2:0]         second_face;
  logic               player;
  logic [3:0]         pairs_left;
  logic [TIMER_W-1:0] timer;

  logic       is_match;
  logic [1:0] res_status;
  logic       flip_ok;

  assign is_match   = (first_face == second_face);
  assign res_status = is_match ? ST_MATCHED : ST_HIDDEN;
  // Only a hidden card under the cursor can be turned; face-up and matched/unused cards are inert.
  assign flip_ok    = flip && (mem.mem_rdata[4:3] == ST_HIDDEN);

  always_comb begin
    mem.mem_addr  = sel_pos;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    case (state)
      S_CLEAR: begin
        mem.mem_addr  = idx;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = {ST_HIDDEN, idx[3:1]};
      end
      S_SHUF_RI: mem.mem_addr = idx;
      S_SHUF_RJ: mem.mem_addr = jdx;
      S_SHUF_WI: begin
        mem.mem_addr  = idx;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = tj;
      end
      S_SHUF_WJ: begin
        mem.mem_addr  = jdx;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = ti;
      end
      S_WAIT1, S_WAIT2: begin
        mem.mem_we    = flip_ok;
        mem.mem_wdata = {ST_FACEUP, mem.mem_rdata[2:0]};
      end
      S_RES_A: begin
        mem.mem_addr  = first_pos;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = {res_status, first_face};
      end
      S_RES_B: begin
        mem.mem_addr  = second_pos;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = {res_status, second_face};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state)
      S_IDLE:  game_state = 2'b00;
      S_DONE:  game_state = 2'b11;
      default: game_state = player ? 2'b10 : 2'b01;
    endcase
  end

  assign busy = (state inside {S_CLEAR, S_SHUF_RI, S_SHUF_RJ, S_SHUF_WI, S_SHUF_WJ,
                               S_SHOW, S_RES_A, S_RES_B});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      jdx         <= '0;
      ti          <= '0;
      tj          <= '0;
      first_pos   <= '0;
      second_pos  <= '0;
      first_face  <= '0;
      second_face <= '0;
      player      <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      pairs_left  <= 4'd8;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
        S_CLEAR: begin
          if (idx == 4'd15) begin
            state <= S_SHUF_RI;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_SHUF_RI: begin
          ti    <= mem.mem_rdata;
          jdx   <= rand_val;
          state <= S_SHUF_RJ;
        end
        S_SHUF_RJ: begin
          tj    <= mem.mem_rdata;
          state <= S_SHUF_WI;
        end
        S_SHUF_WI: state <= S_SHUF_WJ;
        S_SHUF_WJ: begin
          if (idx == 4'd1) begin
            state <= S_WAIT1;
          end else begin
            idx   <= idx - 4'd1;
            state <= S_SHUF_RI;
          end
        end
        S_WAIT1: begin
          if (flip_ok) begin
            first_pos  <= sel_pos;
            first_face <= mem.mem_rdata[2:0];
            state      <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          if (flip_ok) begin
            second_pos  <= sel_pos;
            second_face <= mem.mem_rdata[2:0];
            timer       <= TIMER_W'(SHOW_CYCLES - 1);
            state       <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (timer == '0) begin
            state <= S_RES_A;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        S_RES_A: state <= S_RES_B;
        S_RES_B: begin
          // A scoring player keeps the turn; a miss hands it over.
          if (is_match) begin
            if (player) begin
              p2_score <= p2_score + 4'd1;
            end else begin
              p1_score <= p1_score + 4'd1;
            end
            pairs_left <= pairs_left - 4'd1;
            state      <= (pairs_left == 4'd1) ? S_DONE : S_WAIT1;
          end else begin
            player <= ~player;
            state  <= S_WAIT1;
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl with a behavioural card RAM and a scoreboard of turn outcomes.
module tb_match_game_ctrl;
  localparam int SHOW = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       flip;
  logic [3:0] sel_pos;
  logic [3:0] rand_val;
  logic [1:0] game_state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       busy;

  match_game_ctrl_if bus ();

  match_game_ctrl #(.SHOW_CYCLES(SHOW), .TIMER_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .flip       (flip),
    .sel_pos    (sel_pos),
    .rand_val   (rand_val),
    .mem        (bus),
    .game_state (game_state),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [4:0] mem [16];
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt            <= wr_cnt + 1;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  logic [4:0] gold [16];
  int         pos_a [8];
  int         pos_b [8];
  int         m_player;
  int         m_p1;
  int         m_p2;
  int         m_pairs;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(string tag, logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
      end
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic flip_at(int p);
    sel_pos = 4'(p);
    flip    = 1'b1;
    @(negedge clk);
    flip    = 1'b0;
  endtask

  task automatic reset_model();
    m_player = 0;
    m_p1     = 0;
    m_p2     = 0;
    m_pairs  = 8;
  endtask

  // Issues start (with a concurrent flip that must be dropped) and runs to the first WAIT1 cycle.
  task automatic start_game(bit rnd);
    int w0;
    w0      = wr_cnt;
    start   = 1'b1;
    flip    = 1'b1;
    sel_pos = 4'd3;
    for (int k = 1; k <= 77; k++) begin
      if (rnd) rand_val = 4'($urandom_range(15));
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        flip  = 1'b0;
        check("busy_rise", busy, 1);
        check("gs_clear", game_state, 1);
      end
      if (k == 40) flip = 1'b1;
      if (k == 41) flip = 1'b0;
      if (k == 76) check("busy_last_shuffle", busy, 1);
    end
    rand_val = 4'd0;
    check("busy_wait1", busy, 0);
    check("gs_wait1", game_state, 1);
    check("init_write_count", wr_cnt - w0, 46);
  endtask

  // One player turn; the outcome is predicted from the golden deck before the flips are driven.
  task automatic turn(int a, int b, bit detail);
    logic [1:0] st;
    int         w0;
    bit         m;
    m  = (gold[a][2:0] == gold[b][2:0]);
    st = m ? 2'b10 : 2'b00;
    if (m) begin
      if (m_player == 0) m_p1++;
      else m_p2++;
      m_pairs--;
    end else begin
      m_player = 1 - m_player;
    end
    sb_push($sformatf("status_pos%0d", a), st);
    sb_push($sformatf("status_pos%0d", b), st);
    sb_push("game_state", (m_pairs == 0) ? 3 : ((m_player == 0) ? 1 : 2));
    sb_push("p1_score", m_p1);
    sb_push("p2_score", m_p2);

    flip_at(a);
    check("first_faceup", mem[a][4:3], 2'b01);
    flip_at(b);
    check("second_faceup", mem[b][4:3], 2'b01);
    check("show_busy", busy, 1);
    if (detail) begin
      w0 = wr_cnt;
      flip_at(pos_a[7]);
      repeat (SHOW - 1) @(negedge clk);
      check("show_flip_no_write", wr_cnt - w0, 0);
      @(negedge clk);
      check("res_a_first", mem[a][4:3], st);
      check("res_a_second_pending", mem[b][4:3], 2'b01);
      @(negedge clk);
    end else begin
      repeat (SHOW + 2) @(negedge clk);
    end
    sb_pop(mem[a][4:3]);
    sb_pop(mem[b][4:3]);
    sb_pop(game_state);
    sb_pop(p1_score);
    sb_pop(p2_score);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int cnt;
    logic [4:0] t;

    reset_n  = 1'b0;
    start    = 1'b0;
    flip     = 1'b0;
    sel_pos  = 4'd0;
    rand_val = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_game_state", game_state, 0);
    check("rst_p1", p1_score, 0);
    check("rst_p2", p2_score, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", bus.mem_we, 0);
    reset_n = 1'b1;

    // Game 1: rand_val=0, so every swap is with entry 0.
    start_game(0);
    for (int k = 0; k < 16; k++) gold[k] = {2'b00, 3'(k >> 1)};
    for (int i = 15; i >= 1; i--) begin
      t       = gold[i];
      gold[i] = gold[0];
      gold[0] = t;
    end
    for (int k = 0; k < 16; k++) check($sformatf("deck_entry%0d", k), mem[k], gold[k]);
    for (int f = 0; f < 8; f++) pos_a[f] = -1;
    for (int k = 0; k < 16; k++) begin
      if (pos_a[gold[k][2:0]] < 0) pos_a[gold[k][2:0]] = k;
      else pos_b[gold[k][2:0]] = k;
    end

    reset_model();
    turn(pos_a[0], pos_b[0], 1);
    turn(pos_a[1], pos_a[2], 0);
    w0 = wr_cnt;
    flip_at(pos_a[0]);
    check("matched_flip_no_write", wr_cnt - w0, 0);
    check("matched_flip_gs", game_state, 2);
    check("matched_flip_busy", busy, 0);
    turn(pos_a[1], pos_b[1], 0);
    turn(pos_a[2], pos_b[2], 0);
    turn(pos_a[3], pos_b[3], 0);
    turn(pos_a[4], pos_a[5], 0);
    for (int f = 4; f < 8; f++) turn(pos_a[f], pos_b[f], 0);
    check("final_p1", p1_score, 5);
    check("final_p2", p2_score, 3);

    w0    = wr_cnt;
    start = 1'b1;
    for (int k = 0; k < 4; k++) flip_at(k * 3);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_gs_hold", game_state, 3);
    check("done_no_write", wr_cnt - w0, 0);
    check("done_busy", busy, 0);
    check("done_p1_hold", p1_score, 5);
    check("done_p2_hold", p2_score, 3);

    // Game 2: random swap targets; the deck must still hold two hidden cards of each face.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_from_done_gs", game_state, 0);
    start_game(1);
    for (int f = 0; f < 8; f++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) if (mem[k][2:0] == 3'(f)) cnt++;
      check($sformatf("face%0d_count", f), cnt, 2);
    end
    cnt = 0;
    for (int k = 0; k < 16; k++) if (mem[k][4:3] != 2'b00) cnt++;
    check("all_hidden", cnt, 0);

    // Game 3: same deck as game 1, then reset while two cards are on show.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start_game(0);
    reset_model();
    turn(pos_a[0], pos_b[0], 0);
    flip_at(pos_a[1]);
    flip_at(pos_a[2]);
    repeat (3) @(negedge clk);
    check("show_busy_before_rst", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_show_gs", game_state, 0);
    check("rst_show_p1", p1_score, 0);
    check("rst_show_p2", p2_score, 0);
    check("rst_show_busy", busy, 0);
    check("rst_show_mem_we", bus.mem_we, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_gs", game_state, 0);
    check("idle_hold_busy", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
